// File: rtl/mdu_pkg.sv
// +----------------------------------------------------------------------+
// | mdu_pkg: HI/LO operation codes shared between the controller and MDU  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mdu_pkg;

  localparam int HILO_W = 11;

  localparam logic [HILO_W-1:0] Hilo_none  = 11'h000;
  localparam logic [HILO_W-1:0] Hilo_div   = 11'h001;
  localparam logic [HILO_W-1:0] Hilo_divu  = 11'h002;
  localparam logic [HILO_W-1:0] Hilo_mult  = 11'h004;
  localparam logic [HILO_W-1:0] Hilo_multu = 11'h008;
  localparam logic [HILO_W-1:0] Hilo_ToHi  = 11'h010;
  localparam logic [HILO_W-1:0] Hilo_ToLo  = 11'h020;

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// +----------------------------------------------------------------------+
// | mdu_arith: combinational 32x32 product and quotient/remainder         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [HILO_W-1:0] op_i,
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
  output logic [63:0]       res_o,
  output logic              div0_o
);

  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_q_s, w_r_s;
  logic        w_sdiv;

  always_comb begin
    w_a_sx   = {{32{a_i[31]}}, a_i};
    w_b_sx   = {{32{b_i[31]}}, b_i};
    w_a_zx   = {32'd0, a_i};
    w_b_zx   = {32'd0, b_i};
    div0_o   = (b_i == 32'd0);
    w_sdiv   = (op_i == Hilo_div);
    // Signed divide runs on magnitudes; 0x80000000/-1 then lands on 0x80000000 rem 0.
    w_a_mag  = (w_sdiv && a_i[31]) ? (32'd0 - a_i) : a_i;
    w_b_mag  = (w_sdiv && b_i[31]) ? (32'd0 - b_i) : b_i;
    w_b_safe = div0_o ? 32'd1 : w_b_mag;
    w_q_mag  = w_a_mag / w_b_safe;
    w_r_mag  = w_a_mag % w_b_safe;
    w_q_s    = (a_i[31] ^ b_i[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    w_r_s    = a_i[31] ? (32'd0 - w_r_mag) : w_r_mag;
    res_o    = 64'd0;
    case (op_i)
      Hilo_mult:  res_o = w_a_sx * w_b_sx;
      Hilo_multu: res_o = w_a_zx * w_b_zx;
      Hilo_div:   res_o = {w_r_s, w_q_s};
      Hilo_divu:  res_o = {w_r_mag, w_q_mag};
      default:    res_o = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// +----------------------------------------------------------------------+
// | mdu: multi-cycle multiply/divide unit owning HI/LO.                   |
// | Optional MDU_FLUSH_EN adds a flush input that aborts work.   Rev 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MDU_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              start,
  input  logic [HILO_W-1:0] hiloop,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  output logic              busy,
  output logic [31:0]       hi,
  output logic [31:0]       lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic [63:0]        w_res, pend_d;
  logic               w_div0, w_flush;

`ifdef MDU_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  mdu_arith u_arith (
    .op_i   (hiloop),
    .a_i    (rs_val),
    .b_i    (rt_val),
    .res_o  (w_res),
    .div0_o (w_div0)
  );

  // A zero divisor still occupies the unit but commits the current HI/LO back.
  assign pend_d = (((hiloop == Hilo_div) || (hiloop == Hilo_divu)) && w_div0)
                  ? {hi_q, lo_q} : w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !w_flush) begin
            case (hiloop)
              Hilo_mult, Hilo_multu: begin
                {pend_hi_q, pend_lo_q} <= pend_d;
                cnt_q                  <= CNT_W'(MULT_CYCLES - 1);
                state_q                <= ST_BUSY;
              end
              Hilo_div, Hilo_divu: begin
                {pend_hi_q, pend_lo_q} <= pend_d;
                cnt_q                  <= CNT_W'(DIV_CYCLES - 1);
                state_q                <= ST_BUSY;
              end
              Hilo_ToHi: hi_q <= rs_val;
              Hilo_ToLo: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (w_flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// +----------------------------------------------------------------------+
// | tb_mdu: scoreboard bench for mdu (HI/LO results and busy duration)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mdu;
  import mdu_pkg::*;

  localparam int LIMIT = 40;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [HILO_W-1:0] hiloop = '0;
  logic [31:0]       rs_val = '0;
  logic [31:0]       rt_val = '0;
  logic              busy;
  logic [31:0]       hi, lo;
`ifdef MDU_FLUSH_EN
  logic              flush = 1'b0;
`endif

  exp_t        sb[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          n_vec = 0, n_err = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef MDU_FLUSH_EN
    .flush  (flush),
`endif
    .start  (start),
    .hiloop (hiloop),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [HILO_W-1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] ch,
                                 input logic [31:0] cl);
    int     sa, sb_, q, r;
    longint p;
    logic [63:0] u;
    exp_t   e;
    sa = a; sb_ = b;
    e = {ch, cl};
    if (op == Hilo_mult) begin
      p = longint'(sa) * longint'(sb_);
      e = p;
    end else if (op == Hilo_multu) begin
      u = {32'd0, a} * {32'd0, b};
      e = u;
    end else if (op == Hilo_div && b != 0) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e = {32'd0, 32'h8000_0000};
      else begin
        q = sa / sb_; r = sa % sb_;
        e = {r, q};
      end
    end else if (op == Hilo_divu && b != 0) begin
      e = {a % b, a / b};
    end
    return e;
  endfunction

  // Presents one op for a single sampling edge; returns on the following negedge.
  task automatic drive(input logic [HILO_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; hiloop = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; hiloop = Hilo_none;
  endtask

  task automatic wait_idle(output int cycles, output bit changed);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; cycles = 0; changed = 1'b0;
    while (busy === 1'b1 && cycles < LIMIT) begin
      cycles++;
      if (hi !== h0 || lo !== l0) changed = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input logic [HILO_W-1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    int cyc; bit chg; exp_t e; int want;
    want = (op == Hilo_mult || op == Hilo_multu) ? 5 : 10;
    sb.push_back(model(op, a, b, m_hi, m_lo));
    drive(op, a, b);
    wait_idle(cyc, chg);
    e = sb.pop_front();
    n_vec++; if (cyc != want) begin n_err++; $display("FAIL %s_busy_cycles got %0d want %0d", name, cyc, want); end
    n_vec++; if (chg) begin n_err++; $display("FAIL %s_hilo_during_busy got changed want stable", name); end
    n_vec++; if (hi !== e.hi) begin n_err++; $display("FAIL %s_hi got %h want %h", name, hi, e.hi); end
    n_vec++; if (lo !== e.lo) begin n_err++; $display("FAIL %s_lo got %h want %h", name, lo, e.lo); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_mult();
    run_table("mult_neg2x3", Hilo_mult, 32'hFFFF_FFFE, 32'd3);
    n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_err++; $display("FAIL mult_const got %h want FFFFFFFFFFFFFFFA", {hi, lo}); end
    run_table("multu_max", Hilo_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_vec++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("FAIL multu_const got %h want FFFFFFFE00000001", {hi, lo}); end
  endtask

  task automatic test_div();
    run_table("div_neg7by2", Hilo_div, 32'hFFFF_FFF9, 32'd2);
    n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_const got %h want FFFFFFFFFFFFFFFD", {hi, lo}); end
    run_table("divu_by0", Hilo_divu, 32'd1234, 32'd0);
    n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL divu_by0_const got %h want FFFFFFFFFFFFFFFD", {hi, lo}); end
    run_table("div_ovf", Hilo_div, 32'h8000_0000, 32'hFFFF_FFFF);
    n_vec++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_ovf_const got %h want 0000000080000000", {hi, lo}); end
    run_table("divu_big", Hilo_divu, 32'hF000_0007, 32'd16);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; hiloop = Hilo_ToHi; rs_val = 32'h1234_5678;
    @(negedge clk);
    n_vec++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %b want 0", busy); end
    hiloop = Hilo_ToLo; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; hiloop = Hilo_none;
    n_vec++; if (lo !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL mtlo_lo got %h want 9ABCDEF0", lo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy got %b want 0", busy); end
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_no_effect();
    logic [HILO_W-1:0] codes [2];
    codes[0] = Hilo_none; codes[1] = 11'h400;
    for (int i = 0; i < 2; i++) begin
      drive(codes[i], 32'hDEAD_BEEF, 32'd5);
      n_vec++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL noop_%0d got busy=%b hi=%h lo=%h want 0 %h %h", i, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit chg; exp_t e;
    sb.push_back(model(Hilo_div, 32'd100, 32'd7, m_hi, m_lo));
    drive(Hilo_div, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; hiloop = Hilo_mult; rs_val = 32'd3; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; hiloop = Hilo_none;
    wait_idle(cyc, chg);
    e = sb.pop_front();
    n_vec++; if (cyc + 3 != 10) begin n_err++; $display("FAIL ignore_busy_cycles got %0d want 10", cyc + 3); end
    n_vec++; if ({hi, lo} !== {e.hi, e.lo}) begin n_err++; $display("FAIL ignore_result got %h want %h", {hi, lo}, e); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_rerun got busy=%b want 0", busy); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_random();
    logic [HILO_W-1:0] ops [4];
    ops[0] = Hilo_mult; ops[1] = Hilo_multu; ops[2] = Hilo_div; ops[3] = Hilo_divu;
    for (int i = 0; i < 6; i++)
      run_table("rand", ops[$urandom_range(0, 3)], $urandom, $urandom_range(0, 3) == 0 ? 32'd0 + $urandom_range(1, 9) : $urandom);
  endtask

  task automatic test_async_reset();
    drive(Hilo_mult, 32'd11, 32'd13);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", busy); end
    n_vec++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL arst_hilo got %h %h want 0 0", hi, lo); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; hiloop = Hilo_ToLo; rs_val = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0; hiloop = Hilo_none;
    n_vec++; if (lo !== 32'hCAFE_0001 || hi !== 32'd0) begin n_err++; $display("FAIL arst_first_edge got %h %h want 0 cafe0001", hi, lo); end
    m_lo = 32'hCAFE_0001;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || lo !== 32'hCAFE_0001) begin n_err++; $display("FAIL arst_discard got busy=%b lo=%h want 0 cafe0001", busy, lo); end
  endtask

`ifdef MDU_FLUSH_EN
  task automatic test_flush();
    drive(Hilo_mult, 32'd7, 32'd9);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
    repeat (6) @(negedge clk);
    n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL flush_hilo got %h %h want %h %h", hi, lo, m_hi, m_lo); end
    start = 1'b1; hiloop = Hilo_ToHi; rs_val = 32'h5555_AAAA; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; hiloop = Hilo_none; flush = 1'b0;
    n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL flush_mthi got %h want %h", hi, m_hi); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_no_effect();
    test_back_to_back();
    test_random();
`ifdef MDU_FLUSH_EN
    test_flush();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
